// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
// Handshake: start is taken only on an edge where ready=1; done pulses one cycle when diff/bout/ovf are new.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  ready, done, diff, bout, ovf, zero
  );

  modport slave (
    input  start, a, b, bin,
    output ready, done, diff, bout, ovf, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell plus a borrow flop.
// Operation takes WIDTH RUN cycles followed by a single DONE cycle.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  serial_subtractor_if.slave  bus,
  output logic [1:0]          o_dbg_state
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_br;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_ready;
  logic             r_done;

  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_sr_next;

  // Full-subtractor cell on the current LSBs and the running borrow.
  assign w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  assign w_sr_next = {w_d, r_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_br    <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_br    <= bus.bin;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_br  <= w_br_next;
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt + CW'(1);
          // Last bit: publish the result; w_d is the result MSB.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_diff  <= w_sr_next;
            r_bout  <= w_br_next;
            r_ovf   <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready   = r_ready;
  assign bus.done    = r_done;
  assign bus.diff    = r_diff;
  assign bus.bout    = r_bout;
  assign bus.ovf     = r_ovf;
  assign bus.zero    = (r_diff == '0);
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and an exhaustive WIDTH=2 sweep.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  serial_subtractor_if #(.WIDTH(8)) if8();
  serial_subtractor_if #(.WIDTH(2)) if2();
  logic [1:0] st8;
  logic [1:0] st2;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .bus(if8), .o_dbg_state(st8)
  );
  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .bus(if2), .o_dbg_state(st2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  // Scoreboard entry: {diff[7:0], bout, ovf}
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic logic [9:0] model(input int w, input int a, input int b, input int bin);
    int   d;
    int   m;
    int   df;
    logic bo;
    logic ov;
    d  = a - b - bin;
    m  = (1 << w) - 1;
    df = d & m;
    bo = (d < 0);
    ov = ((((a ^ b) >> (w - 1)) & ((df ^ a) >> (w - 1)) & 1) != 0);
    return {df[7:0], bo, ov};
  endfunction

  task automatic compare_result(input string tag, input logic [31:0] diff, input logic bout,
                                input logic ovf, input logic zero);
    logic [9:0] e;
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h0;
    check({tag, "_diff"}, diff, 32'(e[9:2]));
    check({tag, "_bout"}, 32'(bout), 32'(e[1]));
    check({tag, "_ovf"},  32'(ovf),  32'(e[0]));
    check({tag, "_zero"}, 32'(zero), 32'(e[9:2] == 8'h00));
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!if8.ready && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_ready"}, 32'(if8.ready), 1);
    if8.a = a; if8.b = b; if8.bin = bin; if8.start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(8, int'(a), int'(b), int'(bin)));
    #1;
    if8.start = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if8.done && lat < 40);
    check({tag, "_latency"}, 32'(lat), 9);
    compare_result(tag, 32'(if8.diff), if8.bout, if8.ovf, if8.zero);
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(if8.done), 0);
    check({tag, "_ready_back"}, 32'(if8.ready), 1);
  endtask

  task automatic op2(input int a, input int b, input int bin);
    int lat;
    string tag;
    tag = $sformatf("w2_a%0d_b%0d_bin%0d", a, b, bin);
    @(negedge clk);
    if2.a = 2'(a); if2.b = 2'(b); if2.bin = 1'(bin); if2.start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(2, a, b, bin));
    #1;
    if2.start = 1'b0;
    if2.a = 2'($urandom); if2.b = 2'($urandom); if2.bin = 1'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if2.done && lat < 20);
    check({tag, "_latency"}, 32'(lat), 3);
    compare_result(tag, 32'(if2.diff), if2.bout, if2.ovf, if2.zero);
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(if2.done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ha[3];
    logic [7:0] hb[3];
    logic       hbin[3];
    int acc;
    int prev_acc;
    int lat;
    int ready_bad;
    int seen;

    ha   = '{8'h35, 8'h10, 8'hC8};
    hb   = '{8'h12, 8'h20, 8'h7F};
    hbin = '{1'b0, 1'b1, 1'b1};
    prev_acc = 0;

    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
    if2.start = 1'b0; if2.a = '0; if2.b = '0; if2.bin = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_ready", 32'(if8.ready), 1);
    check("rst_done",  32'(if8.done),  0);
    check("rst_diff",  32'(if8.diff),  0);
    check("rst_bout",  32'(if8.bout),  0);
    check("rst_ovf",   32'(if8.ovf),   0);
    check("rst_zero",  32'(if8.zero),  1);
    check("rst_state", 32'(st8),       0);

    op8(8'h05, 8'h03, 1'b0, "basic");
    op8(8'h03, 8'h05, 1'b0, "neg");
    op8(8'h00, 8'h00, 1'b1, "minus_one");
    op8(8'h80, 8'h01, 1'b0, "ovf_pos");
    op8(8'h7F, 8'hFF, 1'b0, "ovf_neg");
    op8(8'h42, 8'h42, 1'b0, "zero");

    // start held high for three back-to-back operations
    @(negedge clk);
    if8.a = ha[0]; if8.b = hb[0]; if8.bin = hbin[0]; if8.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      acc = cyc;
      if (k > 0) check($sformatf("held%0d_gap", k), 32'(acc - prev_acc), 10);
      prev_acc = acc;
      exp_q.push_back(model(8, int'(ha[k]), int'(hb[k]), int'(hbin[k])));
      if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
      lat = 0;
      ready_bad = 0;
      do begin
        @(negedge clk);
        lat++;
        if (if8.ready) ready_bad++;
        if (lat == 2) check($sformatf("held%0d_state_run", k), 32'(st8), 1);
        if (lat == 4) begin
          if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
        end
      end while (!if8.done && lat < 40);
      check($sformatf("held%0d_latency", k), 32'(lat), 9);
      check($sformatf("held%0d_ready_low", k), 32'(ready_bad), 0);
      compare_result($sformatf("held%0d", k), 32'(if8.diff), if8.bout, if8.ovf, if8.zero);
      if (k < 2) begin
        if8.a = ha[k + 1]; if8.b = hb[k + 1]; if8.bin = hbin[k + 1];
      end else begin
        if8.start = 1'b0;
      end
      @(negedge clk);
      check($sformatf("held%0d_ready_back", k), 32'(if8.ready), 1);
    end

    // reset in the middle of an operation
    op8(8'h10, 8'h01, 1'b0, "pre_rst");
    if8.a = 8'h55; if8.b = 8'h11; if8.bin = 1'b0; if8.start = 1'b1;
    @(posedge clk);
    #1 if8.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrun_diff_hold", 32'(if8.diff), 32'h0F);
    check("midrun_state", 32'(st8), 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(if8.ready), 1);
    check("abort_diff",  32'(if8.diff),  0);
    check("abort_bout",  32'(if8.bout),  0);
    check("abort_ovf",   32'(if8.ovf),   0);
    check("abort_zero",  32'(if8.zero),  1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done) seen++;
    end
    check("abort_no_done", 32'(seen), 0);
    op8(8'h09, 8'h04, 1'b0, "post_rst");

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int bin = 0; bin < 2; bin++)
          op2(a, b, bin);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing diff = a − b − bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the team's gate-level full-adder cell. It gives the datapath a minimal-area multi-cycle SUB unit with a start/done handshake. It sits beside the pipelined CPU's execute stage as an iterative functional unit.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- start  input  1  request; accepted only when ready = 1
- a  input  WIDTH  minuend; sampled on the accepting edge
- b  input  WIDTH  subtrahend; sampled on the accepting edge
- bin  input  1  borrow-in; sampled on the accepting edge
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse when result is valid
- diff  output  WIDTH  registered result; holds until next completion
- bout  output  1  final borrow-out (1 ⇔ unsigned a < b + bin)
- ovf  output  1  signed overflow
- zero  output  1  diff == 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready = 1. start = 1 on an edge latches a, b, bin into shift registers sa, sb and borrow flop br. Counter cnt is cleared to 0. Next state is RUN.
- RUN: each edge processes bit sa[0], sb[0], br:
  - d = sa[0] ^ sb[0] ^ br
  - br ← (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)
  - d shifts into result register sr at the MSB end; sa and sb shift right by one; cnt increments.
  - On the edge where cnt == WIDTH−1: diff ← final sr, bout ← final br, ovf ← (a[MSB] ^ b[MSB]) & (diff[MSB] ^ a[MSB]) using latched operand MSBs. State goes to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. start is ignored in DONE.
- start while in RUN or DONE is ignored. Inputs a, b, bin are don't-care outside the accepting edge.
- zero is combinational from the diff register.
- Arithmetic is modulo 2^WIDTH. bin = 1 subtracts an extra 1. A result of −1 appears as all-ones with bout = 1.
- reset (any state) forces IDLE and clears cnt, br, sa, sb, sr, diff, bout, ovf. An in-progress operation is discarded; no done pulse is produced.
- reset takes priority over start on the same edge.

## Timing
- Reset values: ready = 1, done = 0, diff = 0, bout = 0, ovf = 0, zero = 1.
- Start accepted at edge E0. RUN spans edges E1..EWIDTH. diff, bout and ovf update at edge EWIDTH. done is high in the cycle after EWIDTH, and ready returns high after edge EWIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is edge EWIDTH+2, when start is held.
- diff, bout and ovf change only at completion or reset, never mid-RUN.
- No combinational path from inputs to outputs.

## Test plan
- WIDTH=8: reset 2 cycles, then a=0x05, b=0x03, bin=0 → done exactly 9 cycles after the accept edge, diff=0x02, bout=0, ovf=0, zero=0; done high for 1 cycle only.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1, ovf=0. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1, zero=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF → diff=0x80, ovf=1, bout=1. Then a=0x42, b=0x42 → diff=0x00, zero=1.
- start held high continuously for 3 operations with operands changed mid-RUN → each result uses only the operands latched at its accept edge; accepts are exactly 10 cycles apart; ready stays 0 during RUN/DONE.
- Complete a=0x10, b=0x01 (diff=0x0F). Start a new op, assert reset at RUN cycle 4 → no done pulse; diff=0, bout=0, ready=1 the next cycle. A subsequent op a=0x09, b=0x04 → diff=0x05.
- WIDTH=2 exhaustive: all 32 combinations of a, b, bin are checked against the reference model (a − b − bin) mod 4, and bout is checked against the borrow, with done latency 3 cycles.
